elastic_stage_reg: RTL and testbench

//  Generic parametrised pipeline register for the five-stage core: replaces fixed per-stage regs
//  (IF/ID, ID/EX, ...) with one elastic stage carrying a WIDTH-bit packed control+data bundle.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/sat_counter.sv | 31 +++
 rtl/elastic_stage_reg.sv | 125 ++++++++++++
 tb/tb_elastic_stage_reg.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: elastic-stage state encoding and the state type built on it.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_BUSY  = ST_BUSY,
    S_FULL  = ST_FULL
  } stage_state_e;

  // Only FULL blocks the upstream side; used to derive the registered ready.
  function automatic logic can_accept(input stage_state_e s);
    return (s != S_FULL);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/elastic_stage_reg.sv
// Elastic pipeline stage: valid/ready with a 2-entry skid buffer and registered IN_READY.
// Define STAGE_REG_PERF_EN to build the stall/bubble performance counters.
module elastic_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] BUBBLE_CNT
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;

  logic in_fire;
  logic out_fire;

  assign OUT_VALID = (state_q != S_EMPTY);
  assign IN_READY  = in_ready_q;
  assign OUT_DATA  = main_q;

  assign in_fire  = IN_VALID & in_ready_q;
  assign out_fire = OUT_VALID & OUT_READY;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d = S_BUSY;
          main_d  = IN_DATA;
        end
      end
      S_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = IN_DATA;
        end else if (in_fire) begin
          state_d = S_FULL;
          skid_d  = IN_DATA;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // Upstream is blocked here, so only the drain of main into downstream matters.
        if (out_fire) begin
          state_d = S_BUSY;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase

    if (FLUSH) begin
      state_d = S_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end

    in_ready_d = can_accept(state_d);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef STAGE_REG_PERF_EN
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = OUT_VALID & ~OUT_READY;
  assign bubble_inc = ~OUT_VALID;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc_i (stall_inc),
    .cnt_o (STALL_CNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc_i (bubble_inc),
    .cnt_o (BUBBLE_CNT)
  );
`else
  assign STALL_CNT  = '0;
  assign BUBBLE_CNT = '0;
`endif

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Directed vector table plus scoreboarded random traffic for elastic_stage_reg.
module tb_elastic_stage_reg;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          FLUSH;
  logic          IN_VALID;
  logic          IN_READY;
  logic [W-1:0]  IN_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [W-1:0]  OUT_DATA;
  logic [CW-1:0] STALL_CNT;
  logic [CW-1:0] BUBBLE_CNT;

  int tests = 0;
  int fails = 0;

  elastic_stage_reg #(
    .WIDTH          (W),
    .CLEAR_ON_FLUSH (1'b1),
    .CNT_W          (CW)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .FLUSH      (FLUSH),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_DATA    (IN_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_DATA   (OUT_DATA),
    .STALL_CNT  (STALL_CNT),
    .BUBBLE_CNT (BUBBLE_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         rst_n;
    logic         fl;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         ev;
    logic         er;
    logic [W-1:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, input logic fl, input logic iv, input logic [W-1:0] d,
                              input logic ordy, input logic ev, input logic er, input logic [W-1:0] ed);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ev = ev; v.er = er; v.ed = ed;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  logic [W-1:0] q[$];
  logic [W-1:0] exp_d;
  logic         bound_hit;

  initial begin
    RST_N = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b1; IN_DATA = 16'h0055; OUT_READY = 1'b0;

    // Reset held 3 cycles with IN_VALID asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("[TB] reset cycle %0d: ov=%0b ir=%0b od=0x%0h", i, OUT_VALID, IN_READY, OUT_DATA);
      chk("reset_out_valid", 32'(OUT_VALID), 32'd0);
      chk("reset_in_ready",  32'(IN_READY),  32'd0);
      chk("reset_out_data",  32'(OUT_DATA),  32'd0);
    end
    RST_N = 1'b1; IN_VALID = 1'b0;
    tick();
    $display("[TB] reset release: ov=%0b ir=%0b", OUT_VALID, IN_READY);
    chk("release_in_ready",  32'(IN_READY),  32'd1);
    chk("release_out_valid", 32'(OUT_VALID), 32'd0);

    // Streaming 0x1..0x8
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(1, 0, 1, W'(k), 1, 1, 1, W'(k)));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0008));
    // Backpressure: A held, B into skid, C refused, then A,B drain in order
    vecs.push_back(mk(1, 0, 1, 16'h000A, 1, 1, 1, 16'h000A));
    vecs.push_back(mk(1, 0, 1, 16'h000B, 0, 1, 0, 16'h000A));
    vecs.push_back(mk(1, 0, 1, 16'h000C, 0, 1, 0, 16'h000A));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 16'h000B));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 16'h000B));
    // Flush while FULL with a beat offered
    vecs.push_back(mk(1, 0, 1, 16'h0011, 0, 1, 1, 16'h0011));
    vecs.push_back(mk(1, 0, 1, 16'h0012, 0, 1, 0, 16'h0011));
    vecs.push_back(mk(1, 1, 1, 16'h000C, 0, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0000));
    // Flush in BUSY with concurrent in and out fire
    vecs.push_back(mk(1, 0, 1, 16'h0021, 1, 1, 1, 16'h0021));
    vecs.push_back(mk(1, 1, 1, 16'h0022, 1, 0, 1, 16'h0000));
    // Skid reuse after flush
    vecs.push_back(mk(1, 0, 1, 16'h0031, 0, 1, 1, 16'h0031));
    vecs.push_back(mk(1, 0, 1, 16'h0032, 0, 1, 0, 16'h0031));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 16'h0032));
    vecs.push_back(mk(1, 0, 1, 16'h0033, 1, 1, 1, 16'h0033));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0033));
    // Reset mid-transfer while FULL
    vecs.push_back(mk(1, 0, 1, 16'h0041, 0, 1, 1, 16'h0041));
    vecs.push_back(mk(1, 0, 1, 16'h0042, 0, 1, 0, 16'h0041));
    vecs.push_back(mk(0, 0, 1, 16'h0043, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 1, 16'h0044, 1, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 1, 16'h0045, 1, 1, 1, 16'h0045));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0045));
    // Flush in FULL coinciding with out_fire
    vecs.push_back(mk(1, 0, 1, 16'h0051, 0, 1, 1, 16'h0051));
    vecs.push_back(mk(1, 0, 1, 16'h0052, 0, 1, 0, 16'h0051));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 1, 16'h0000));

    for (int i = 0; i < vecs.size(); i++) begin
      RST_N = vecs[i].rst_n; FLUSH = vecs[i].fl; IN_VALID = vecs[i].iv;
      IN_DATA = vecs[i].d; OUT_READY = vecs[i].ordy;
      tick();
      $display("[TB] vec %0d: rst_n=%0b fl=%0b iv=%0b d=0x%0h or=%0b -> ov=%0b ir=%0b od=0x%0h",
               i, vecs[i].rst_n, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy,
               OUT_VALID, IN_READY, OUT_DATA);
      chk($sformatf("vec%0d_out_valid", i), 32'(OUT_VALID), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_in_ready", i),  32'(IN_READY),  32'(vecs[i].er));
      chk($sformatf("vec%0d_out_data", i),  32'(OUT_DATA),  32'(vecs[i].ed));
    end

    // Random valid/ready traffic against a scoreboard FIFO (stage starts EMPTY here)
    RST_N = 1'b1; FLUSH = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      IN_DATA   = W'($urandom);
      if (OUT_VALID && OUT_READY) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_d = q.pop_front();
          chk("rnd_data", 32'(OUT_DATA), 32'(exp_d));
        end
      end
      if (IN_VALID && IN_READY) q.push_back(IN_DATA);
      tick();
      chk("rnd_occupancy", 32'(q.size() <= 2), 32'd1);
      chk("rnd_out_valid", 32'(OUT_VALID), 32'(q.size() != 0));
      chk("rnd_in_ready",  32'(IN_READY),  32'(q.size() < 2));
    end
    $display("[TB] random phase done, %0d beats left to drain", q.size());

    IN_VALID = 1'b0; OUT_READY = 1'b1;
    bound_hit = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (q.size() == 0) begin
        bound_hit = 1'b0;
        break;
      end
      if (OUT_VALID) begin
        exp_d = q.pop_front();
        chk("drain_data", 32'(OUT_DATA), 32'(exp_d));
      end
      tick();
    end
    if (q.size() == 0) bound_hit = 1'b0;
    chk("drain_timeout", 32'(bound_hit), 32'd0);
    chk("drain_out_valid", 32'(OUT_VALID), 32'd0);

`ifdef STAGE_REG_PERF_EN
    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; FLUSH = 1'b0;
    tick();
    chk("perf_reset_stall",  32'(STALL_CNT),  32'd0);
    chk("perf_reset_bubble", 32'(BUBBLE_CNT), 32'd0);
    RST_N = 1'b1;
    tick();
    IN_VALID = 1'b1; IN_DATA = 16'h0077;
    tick();
    IN_VALID = 1'b0;
    repeat (5) tick();
    $display("[TB] perf stall: stall=%0d", STALL_CNT);
    chk("perf_stall_5", 32'(STALL_CNT), 32'd5);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("perf_stall_kept_on_flush", 32'(STALL_CNT), 32'd6);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    repeat (20) tick();
    $display("[TB] perf bubble: bubble=%0d stall=%0d", BUBBLE_CNT, STALL_CNT);
    chk("perf_bubble_sat", 32'(BUBBLE_CNT), 32'd15);
    chk("perf_stall_idle", 32'(STALL_CNT),  32'd0);
`else
    chk("perf_off_stall",  32'(STALL_CNT),  32'd0);
    chk("perf_off_bubble", 32'(BUBBLE_CNT), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
